regfile: RTL and testbench

//  General-purpose register file at the writeback end of the MIPS pipeline; sink of the
//  EX-stage write triple (w_reg_en/w_reg_addr/w_reg_data) after it passes the MEM/WB stages.

---
 rtl/regfile.sv | 95 +++++++++
 tb/tb_regfile.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- MIPS general-purpose register file (writeback sink, ID source)
//
// Ports
//   clk            rising-edge clock for all register updates
//   rst_n          asynchronous active-low reset; clears every register
//   w_reg_en_in    write enable from WB
//   w_reg_addr_in  write address (writes to address 0 are dropped)
//   w_reg_data_in  write data
//   r1_en_in       read port 1 enable
//   r1_addr_in     read port 1 address
//   r1_data_out    read port 1 data, combinational, with write bypass
//   r2_en_in       read port 2 enable
//   r2_addr_in     read port 2 address
//   r2_data_out    read port 2 data, combinational, with write bypass
//   dbg_addr_in    debug read address
//   dbg_data_out   committed value of dbg_addr_in (never bypassed)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_NUM        = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
    input  logic                      r1_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] r1_addr_in,
    output logic [REG_DATA_WIDTH-1:0] r1_data_out,
    input  logic                      r2_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] r2_addr_in,
    output logic [REG_DATA_WIDTH-1:0] r2_data_out,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_in,
    output logic [REG_DATA_WIDTH-1:0] dbg_data_out
);

    logic [REG_DATA_WIDTH-1:0] regs_q [REG_NUM];
    logic [REG_DATA_WIDTH-1:0] regs_d [REG_NUM];

    // Qualified write: address 0 is hardwired to zero, so it is never stored.
    logic w_valid;
    assign w_valid = w_reg_en_in && (w_reg_addr_in != '0);

    always_comb begin
        regs_d = regs_q;
        if (w_valid) begin
            regs_d[w_reg_addr_in] = w_reg_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read priority: reset, disabled port, r0, same-cycle write bypass, array.
    // The bypass only fires for nonzero addresses because r0 is resolved first.
    function automatic logic [REG_DATA_WIDTH-1:0] read_port(
        input logic                      en,
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        logic [REG_DATA_WIDTH-1:0] val;
        val = '0;
        if (!rst_n || !en || (addr == '0)) begin
            val = '0;
        end else if (w_reg_en_in && (w_reg_addr_in == addr)) begin
            val = w_reg_data_in;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        r1_data_out = read_port(r1_en_in, r1_addr_in);
    end

    always_comb begin
        r2_data_out = read_port(r2_en_in, r2_addr_in);
    end

    // Debug view shows committed state only; r0 is always zero in the array.
    always_comb begin
        dbg_data_out = '0;
        if (rst_n) begin
            dbg_data_out = regs_q[dbg_addr_in];
        end
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          r1_en;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_data;
    logic          r2_en;
    logic [AW-1:0] r2_addr;
    logic [DW-1:0] r2_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    regfile #(
        .REG_DATA_WIDTH(DW),
        .REG_ADDR_WIDTH(AW),
        .REG_NUM       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_reg_en_in  (w_en),
        .w_reg_addr_in(w_addr),
        .w_reg_data_in(w_data),
        .r1_en_in     (r1_en),
        .r1_addr_in   (r1_addr),
        .r1_data_out  (r1_data),
        .r2_en_in     (r2_en),
        .r2_addr_in   (r2_addr),
        .r2_data_out  (r2_data),
        .dbg_addr_in  (dbg_addr),
        .dbg_data_out (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        w_en     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        r1_en    = 1'b1;
        r1_addr  = 5'd5;
        r2_en    = 1'b1;
        r2_addr  = 5'd5;
        dbg_addr = 5'd5;
        #1;
        check("rst_r1", r1_data, 32'h0);
        check("rst_r2", r2_data, 32'h0);
        check("rst_dbg", dbg_data, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1) write r5, then reset mid-cycle clears it immediately
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
        tick();
        w_en = 1'b0;
        check("t1_dbg_written", dbg_data, 32'hDEAD_BEEF);
        check("t1_r1_written", r1_data, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_r1_in_reset", r1_data, 32'h0);
        check("t1_dbg_in_reset", dbg_data, 32'h0);
        // write attempted while reset is held must be lost
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'h1111_1111;
        #1;
        check("t1_bypass_in_reset", r1_data, 32'h0);
        tick();
        w_en = 1'b0;
        rst_n = 1'b1;
        #1;
        check("t1_r1_after_rel", r1_data, 32'h0);
        check("t1_dbg_after_rel", dbg_data, 32'h0);

        // 2) write/read with port enable
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h0000_1234;
        tick();
        w_en = 1'b0;
        r1_en = 1'b1; r1_addr = 5'd3;
        r2_en = 1'b0; r2_addr = 5'd3;
        #1;
        check("t2_r1_read", r1_data, 32'h0000_1234);
        check("t2_r2_disabled", r2_data, 32'h0);
        r1_en = 1'b0;
        r2_en = 1'b1;
        #1;
        check("t2_r1_disabled", r1_data, 32'h0);
        check("t2_r2_read", r2_data, 32'h0000_1234);

        // 3) bypass on both ports; debug keeps old value until the edge
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h0BAD_F00D;
        tick();
        w_data = 32'hA5A5_A5A5;
        r1_en = 1'b1; r1_addr = 5'd7;
        r2_en = 1'b1; r2_addr = 5'd7;
        dbg_addr = 5'd7;
        #1;
        check("t3_r1_bypass", r1_data, 32'hA5A5_A5A5);
        check("t3_r2_bypass", r2_data, 32'hA5A5_A5A5);
        check("t3_dbg_old", dbg_data, 32'h0BAD_F00D);
        tick();
        w_en = 1'b0;
        #1;
        check("t3_dbg_new", dbg_data, 32'hA5A5_A5A5);
        check("t3_r1_stored", r1_data, 32'hA5A5_A5A5);

        // 4) register 0 stays zero, no bypass
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF;
        r1_addr = 5'd0; r2_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        check("t4_r1_same", r1_data, 32'h0);
        check("t4_r2_same", r2_data, 32'h0);
        check("t4_dbg_same", dbg_data, 32'h0);
        tick();
        w_en = 1'b0;
        #1;
        check("t4_r1_next", r1_data, 32'h0);
        check("t4_r2_next", r2_data, 32'h0);
        check("t4_dbg_next", dbg_data, 32'h0);

        // 5) back-to-back writes to r9
        r2_addr = 5'd9; dbg_addr = 5'd9;
        for (int k = 1; k <= 3; k++) begin
            w_en = 1'b1; w_addr = 5'd9; w_data = DW'(k);
            #1;
            check($sformatf("t5_r2_w%0d", k), r2_data, DW'(k));
            if (k > 1) check($sformatf("t5_dbg_w%0d", k - 1), dbg_data, DW'(k - 1));
            tick();
        end
        w_en = 1'b0;
        #1;
        check("t5_dbg_w3", dbg_data, 32'd3);
        check("t5_r2_final", r2_data, 32'd3);

        // 6) sweep all registers, skewed read addresses
        for (int i = 1; i < 32; i++) begin
            w_en = 1'b1; w_addr = AW'(i); w_data = DW'(i) * 32'h0101_0101;
            tick();
        end
        w_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r1_addr  = AW'(i);
            r2_addr  = AW'((i + 7) % 32);
            dbg_addr = AW'((i + 13) % 32);
            #1;
            check($sformatf("t6_r1_a%0d", i), r1_data, DW'(i) * 32'h0101_0101);
            check($sformatf("t6_r2_a%0d", (i + 7) % 32), r2_data, DW'((i + 7) % 32) * 32'h0101_0101);
            check($sformatf("t6_dbg_a%0d", (i + 13) % 32), dbg_data, DW'((i + 13) % 32) * 32'h0101_0101);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
